// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver paired with a shared baud generator.
// Frames are LSB first with one stop bit; received bytes use a valid/read handshake.
`timescale 1ns/1ps
module uart_rx_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rs232_rx,
    input  logic                 clk_bps,
    input  logic                 rx_rd,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_d;
    logic                 rx_fall;
    logic [CW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] rx_data_sh;

    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rs232_rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign rx_fall = ~rx_s & rx_d;

    // Frame FSM; all outputs registered, pulses default low each clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bps_start  <= 1'b0;
            bit_cnt    <= '0;
            rx_data_sh <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_rd && rx_valid) begin
                rx_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (rx_fall) begin
                        state     <= START;
                        bps_start <= 1'b1;
                    end
                end
                START: begin
                    if (clk_bps) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state     <= IDLE;
                            bps_start <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (clk_bps) begin
                        rx_data_sh[bit_cnt] <= rx_s;
                        if (bit_cnt == LAST) begin
                            state   <= STOP;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                STOP: begin
                    if (clk_bps) begin
                        state     <= IDLE;
                        bps_start <= 1'b0;
                        if (rx_s) begin
                            rx_data  <= rx_data_sh;
                            rx_valid <= 1'b1;
                            overrun  <= rx_valid & ~rx_rd;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    bps_start <= 1'b0;
                end
            endcase
        end
    end

endmodule
